fp_sort_engine: RTL and testbench

// - In-place sorter for DEPTH 13-bit floating-point words {sign, exp[3:0], mag[7:0]}.
// - Value = (-1)^sign * 0.mag * 2^exp.
// - Host loads the array, pulses start, waits for done, then reads the sorted array.
// - One shared compare datapath is time-multiplexed by an early-exit bubble-sort FSM.

---
 rtl/fp_sort_engine.sv | 121 ++++++++++++
 tb/tb_fp_sort_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp_sort_engine.sv
// rtl/fp_sort_engine.sv - in-place early-exit bubble sorter for 13-bit {sign, exp, mag} words
// Define FP_SORT_STATS_EN to add the saturating swap_count output.
module fp_sort_engine #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [12:0]   wr_data,
  input  logic          start,
  input  logic [AW-1:0] rd_addr,
  output logic [12:0]   rd_data,
  output logic          busy,
  output logic          done
`ifdef FP_SORT_STATS_EN
  ,
  output logic [7:0]    swap_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_CHECK, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 2);
  localparam bit            POW2     = (DEPTH == (1 << AW));

  state_t        state, state_nx;
  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] idx, idx_nx, pass;
  logic          swapped, do_swap, wr_ok, rd_ok;
  logic [12:0]   cmp_a, cmp_b;

  // Sign-magnitude ordering on raw {exp, mag}; equal words never compare greater.
  function automatic logic fp_gt(input logic [12:0] a, input logic [12:0] b);
    if (a[12] != b[12]) return b[12];
    else if (!a[12])    return a[11:0] > b[11:0];
    else                return a[11:0] < b[11:0];
  endfunction

  if (POW2) begin : g_full_range
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
  end else begin : g_part_range
    assign wr_ok = (32'(wr_addr) < 32'(DEPTH));
    assign rd_ok = (32'(rd_addr) < 32'(DEPTH));
  end

  assign idx_nx  = idx + AW'(1);
  assign cmp_a   = mem[idx];
  assign cmp_b   = mem[idx_nx];
  assign do_swap = fp_gt(cmp_a, cmp_b);
  assign rd_data = rd_ok ? mem[rd_addr] : 13'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_COMPARE;
      S_COMPARE: if (idx == LAST_IDX) state_nx = S_CHECK;
      S_CHECK:   state_nx = (!swapped || pass == LAST_IDX) ? S_DONE : S_COMPARE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_COMPARE) || (state == S_CHECK);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      idx     <= '0;
      pass    <= '0;
      swapped <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A write in the start cycle lands before the first compare reads mem.
          if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
          if (start) begin
            idx     <= '0;
            pass    <= '0;
            swapped <= 1'b0;
          end
        end
        S_COMPARE: begin
          if (do_swap) begin
            mem[idx]    <= cmp_b;
            mem[idx_nx] <= cmp_a;
            swapped     <= 1'b1;
          end
          if (idx != LAST_IDX) idx <= idx_nx;
        end
        S_CHECK: begin
          if (swapped && pass != LAST_IDX) begin
            pass    <= pass + AW'(1);
            idx     <= '0;
            swapped <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FP_SORT_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        swap_count <= 8'h0;
    else if (state == S_IDLE && start)                swap_count <= 8'h0;
    else if (state == S_COMPARE && do_swap && swap_count != 8'hFF)
                                                      swap_count <= swap_count + 8'h1;
  end
`endif

endmodule

// File: tb/tb_fp_sort_engine.sv
// tb/tb_fp_sort_engine.sv - directed self-checking bench for fp_sort_engine (DEPTH=8)
module tb_fp_sort_engine;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [12:0]   wr_data = '0;
  logic [12:0]   rd_data;
  logic          busy, done;
`ifdef FP_SORT_STATS_EN
  logic [7:0]    swap_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int edges, n_done, first_done;

  logic [12:0] pre [DEPTH];
  logic [12:0] rev [DEPTH];
  logic [12:0] mix_in [DEPTH];
  logic [12:0] mix_out [DEPTH];
  logic [12:0] same_out [DEPTH];
  logic [12:0] zeros [DEPTH];

  always #5 clk = ~clk;

  fp_sort_engine #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done)
`ifdef FP_SORT_STATS_EN
    ,
    .swap_count (swap_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [12:0] w [DEPTH]);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = w[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_all(input string tag, input logic [12:0] exp [DEPTH]);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      #1;
      check($sformatf("%s[%0d]", tag, i), 32'(rd_data), 32'(exp[i]));
    end
  endtask

  // Counts edges from the start-sampling edge until done is seen.
  task automatic start_and_wait(input bit do_wr, input logic [12:0] wdata, output int n);
    @(negedge clk);
    start = 1'b1;
    if (do_wr) begin wr_en = 1'b1; wr_addr = AW'(DEPTH - 1); wr_data = wdata; end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    pre      = '{13'h1340, 13'h1180, 13'h0000, 13'h0110, 13'h0120, 13'h0201, 13'h0500, 13'h0FFF};
    mix_in   = '{13'h0000, 13'h1000, 13'h0280, 13'h1280, 13'h0240, 13'h1240, 13'h0280, 13'h1001};
    mix_out  = '{13'h1280, 13'h1240, 13'h1001, 13'h1000, 13'h0000, 13'h0240, 13'h0280, 13'h0280};
    same_out = '{13'h1340, 13'h1180, 13'h0000, 13'h0110, 13'h0120, 13'h0201, 13'h0300, 13'h0500};
    for (int i = 0; i < DEPTH; i++) begin
      rev[i]   = pre[DEPTH - 1 - i];
      zeros[i] = 13'h0;
    end

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    read_all("rst_mem", zeros);
`ifdef FP_SORT_STATS_EN
    check("rst_swaps", 32'(swap_count), 32'd0);
`endif

    load(pre);
    start_and_wait(1'b0, 13'h0, edges);
    check("pre_edges", 32'(edges), 32'd8);
    read_all("pre_mem", pre);
`ifdef FP_SORT_STATS_EN
    check("pre_swaps", 32'(swap_count), 32'd0);
`endif

    load(rev);
    start_and_wait(1'b0, 13'h0, edges);
    check("rev_edges", 32'(edges), 32'd56);
    read_all("rev_mem", pre);
`ifdef FP_SORT_STATS_EN
    check("rev_swaps", 32'(swap_count), 32'd28);
`endif

    load(mix_in);
    start_and_wait(1'b0, 13'h0, edges);
    read_all("mix_mem", mix_out);

    // start/wr_en pulsed while busy and again during the done cycle must be ignored.
    load(rev);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    first_done = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (c == 5 || done) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 13'h1FFF;
      end
    end
    start = 1'b0; wr_en = 1'b0;
    check("busy_done_cnt", 32'(n_done), 32'd1);
    check("busy_done_at", 32'(first_done), 32'd56);
    read_all("busy_mem", pre);
`ifdef FP_SORT_STATS_EN
    check("busy_swaps", 32'(swap_count), 32'd28);
`endif

    load(rev);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    read_all("midrst_mem", zeros);
`ifdef FP_SORT_STATS_EN
    check("midrst_swaps", 32'(swap_count), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    load(mix_in);
    start_and_wait(1'b0, 13'h0, edges);
    read_all("postrst_mem", mix_out);

    load(pre);
    start_and_wait(1'b1, 13'h0300, edges);
    check("same_edges", 32'(edges), 32'd16);
    read_all("same_mem", same_out);
`ifdef FP_SORT_STATS_EN
    check("same_swaps", 32'(swap_count), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
